// File: rtl/mtx_ser_pkg.sv
// Shared mio constants: legal IO bus widths and byte-count helpers.
package mtx_ser_pkg;

  localparam int unsigned MioWordBits  = 64;
  localparam int unsigned MioWordBytes = 8;

  function automatic bit mio_iow_legal(input int unsigned iow);
    return (iow == 8) || (iow == 16) || (iow == 32) || (iow == 64);
  endfunction

  function automatic int unsigned mio_bpb(input int unsigned iow);
    return iow / 8;
  endfunction

  // Highest set valid bit plus one; gaps below it count as valid.
  function automatic logic [3:0] mio_nbytes(input logic [7:0] valid);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < MioWordBytes; i++) begin
      if (valid[i]) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/mtx_ser.sv
// Serialises 64-bit FIFO words into IOW-bit link beats with registered outputs
// and zero-bubble back-to-back word loading.
module mtx_ser
  import mtx_ser_pkg::*;
#(
  parameter int unsigned IOW = 16
) (
  input  logic               io_clk,
  input  logic               nreset,
  input  logic               tx_en,
  input  logic [63:0]        io_packet,
  input  logic [7:0]         io_valid,
  output logic               io_wait,
  input  logic               tx_wait,
  output logic               tx_access,
  output logic [IOW-1:0]     tx_packet,
  output logic [IOW/8-1:0]   tx_bvalid
);

  localparam int unsigned BPB    = mio_bpb(IOW);
  localparam int unsigned NBEATS = MioWordBits / IOW;
  localparam int unsigned CW     = $clog2(NBEATS) + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  if (!mio_iow_legal(IOW)) begin : g_bad_iow
    $error("mtx_ser: illegal IOW %0d", IOW);
  end

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    sr_q, sr_d;
  logic [BPB-1:0] lmask_q, lmask_d;
  logic           tx_access_q, tx_access_d;
  logic [IOW-1:0] tx_packet_q, tx_packet_d;
  logic [BPB-1:0] tx_bvalid_q, tx_bvalid_d;

  logic           last_beat, load_ok, accept, drive;
  logic [3:0]     nbytes;
  logic [CW-1:0]  new_beats;
  logic [BPB-1:0] new_lmask, beat_mask;
  int unsigned    rem;

  assign last_beat = (cnt_q == CW'(1));
  assign load_ok   = tx_en & ((state_q == StIdle) |
                              ((state_q == StShift) & last_beat & ~tx_wait));
  assign accept    = load_ok & (|io_valid);
  assign io_wait   = ~load_ok;

  always_comb begin
    nbytes    = mio_nbytes(io_valid);
    new_beats = CW'((32'(nbytes) + BPB - 1) / BPB);
    rem       = 32'(nbytes) % BPB;
    // A whole final beat (remainder 0) is fully valid.
    new_lmask = (rem == 0) ? '1 : BPB'((32'd1 << rem) - 32'd1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    lmask_d     = lmask_q;
    tx_access_d = tx_access_q;
    tx_packet_d = tx_packet_q;
    tx_bvalid_d = tx_bvalid_q;
    drive       = 1'b0;
    beat_mask   = '1;
    if (accept) begin
      state_d   = StShift;
      sr_d      = io_packet;
      cnt_d     = new_beats;
      lmask_d   = new_lmask;
      drive     = 1'b1;
      beat_mask = (new_beats == CW'(1)) ? new_lmask : '1;
    end else if ((state_q == StShift) && !tx_wait) begin
      if (last_beat) begin
        state_d     = StIdle;
        cnt_d       = '0;
        sr_d        = '0;
        lmask_d     = '0;
        tx_access_d = 1'b0;
        tx_packet_d = '0;
        tx_bvalid_d = '0;
      end else begin
        sr_d      = sr_q >> IOW;
        cnt_d     = cnt_q - CW'(1);
        drive     = 1'b1;
        beat_mask = (cnt_q == CW'(2)) ? lmask_q : '1;
      end
    end
    if (drive) begin
      tx_access_d = 1'b1;
      tx_bvalid_d = beat_mask;
      for (int b = 0; b < BPB; b++) begin
        tx_packet_d[b*8 +: 8] = beat_mask[b] ? sr_d[b*8 +: 8] : 8'h00;
      end
    end
  end

  always_ff @(posedge io_clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      lmask_q     <= '0;
      tx_access_q <= 1'b0;
      tx_packet_q <= '0;
      tx_bvalid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      lmask_q     <= lmask_d;
      tx_access_q <= tx_access_d;
      tx_packet_q <= tx_packet_d;
      tx_bvalid_q <= tx_bvalid_d;
    end
  end

  assign tx_access = tx_access_q;
  assign tx_packet = tx_packet_q;
  assign tx_bvalid = tx_bvalid_q;

endmodule

// File: tb/tb_mtx_ser.sv
// Directed self-checking bench for mtx_ser at IOW=16.
module tb_mtx_ser;

  localparam int unsigned IOW = 16;

  logic            io_clk = 1'b0;
  logic            nreset;
  logic            tx_en;
  logic [63:0]     io_packet;
  logic [7:0]      io_valid;
  logic            io_wait;
  logic            tx_wait;
  logic            tx_access;
  logic [IOW-1:0]  tx_packet;
  logic [IOW/8-1:0] tx_bvalid;

  int n_checks = 0;
  int n_pass   = 0;

  mtx_ser #(.IOW(IOW)) u_dut (
    .io_clk    (io_clk),
    .nreset    (nreset),
    .tx_en     (tx_en),
    .io_packet (io_packet),
    .io_valid  (io_valid),
    .io_wait   (io_wait),
    .tx_wait   (tx_wait),
    .tx_access (tx_access),
    .tx_packet (tx_packet),
    .tx_bvalid (tx_bvalid)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [15:0] pkt, input logic [1:0] bv);
    check({tag, ".acc"}, 64'(tx_access), 64'd1);
    check({tag, ".pkt"}, 64'(tx_packet), 64'(pkt));
    check({tag, ".bv"},  64'(tx_bvalid), 64'(bv));
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".acc"}, 64'(tx_access), 64'd0);
    check({tag, ".pkt"}, 64'(tx_packet), 64'd0);
    check({tag, ".bv"},  64'(tx_bvalid), 64'd0);
  endtask

  task automatic wait_chk(input string tag, input logic exp);
    #1;
    check(tag, 64'(io_wait), 64'(exp));
  endtask

  initial begin
    nreset    = 1'b0;
    tx_en     = 1'b0;
    io_packet = '0;
    io_valid  = '0;
    tx_wait   = 1'b0;
    #12;
    idle_chk("rst");
    wait_chk("rst.iowait_txen0", 1'b1);
    nreset = 1'b1;
    tick();
    tx_en = 1'b1;
    wait_chk("idle.iowait", 1'b0);

    // Full word, four beats.
    io_packet = 64'h8877665544332211;
    io_valid  = 8'hFF;
    tick();
    io_valid = 8'h00;
    beat("full.b0", 16'h2211, 2'b11);
    wait_chk("full.b0.iowait", 1'b1);
    tick(); beat("full.b1", 16'h4433, 2'b11);
    tick(); beat("full.b2", 16'h6655, 2'b11);
    tick(); beat("full.b3", 16'h8877, 2'b11);
    wait_chk("full.b3.iowait", 1'b0);
    tick(); idle_chk("full.end");

    // Single byte word.
    io_packet = 64'hFFFFFFFFFFFFFFAB;
    io_valid  = 8'h01;
    tick();
    io_valid = 8'h00;
    beat("one.b0", 16'h00AB, 2'b01);
    wait_chk("one.iowait", 1'b0);
    tick(); idle_chk("one.end");

    // Gap in valids, partial last beat.
    io_packet = 64'h9988776655443322;
    io_valid  = 8'h05;
    tick();
    io_valid = 8'h00;
    beat("gap.b0", 16'h3322, 2'b11);
    tick(); beat("gap.b1", 16'h0044, 2'b01);
    tick(); idle_chk("gap.end");

    // Back-to-back words, no bubble.
    io_packet = 64'hA4A4A3A3A2A2A1A1;
    io_valid  = 8'hFF;
    tick();
    io_packet = 64'hB4B4B3B3B2B2B1B1;
    beat("b2b.a0", 16'hA1A1, 2'b11); wait_chk("b2b.a0.iowait", 1'b1);
    tick(); beat("b2b.a1", 16'hA2A2, 2'b11); wait_chk("b2b.a1.iowait", 1'b1);
    tick(); beat("b2b.a2", 16'hA3A3, 2'b11); wait_chk("b2b.a2.iowait", 1'b1);
    tick(); beat("b2b.a3", 16'hA4A4, 2'b11); wait_chk("b2b.a3.iowait", 1'b0);
    tick();
    io_valid = 8'h00;
    beat("b2b.b0", 16'hB1B1, 2'b11); wait_chk("b2b.b0.iowait", 1'b1);
    tick(); beat("b2b.b1", 16'hB2B2, 2'b11);
    tick(); beat("b2b.b2", 16'hB3B3, 2'b11);
    tick(); beat("b2b.b3", 16'hB4B4, 2'b11);
    tick(); idle_chk("b2b.end");

    // Stall on beat 1 of a 6-byte word.
    io_packet = 64'hDEADCC55BB44AA33;
    io_valid  = 8'h3F;
    tick();
    io_valid = 8'h00;
    beat("stl.b0", 16'hAA33, 2'b11);
    tick();
    beat("stl.b1", 16'hBB44, 2'b11);
    tx_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("stl.hold", 16'hBB44, 2'b11);
    end
    tx_wait = 1'b0;
    tick();
    beat("stl.b2", 16'hCC55, 2'b11);
    tx_wait = 1'b1;
    wait_chk("stl.last.iowait_held", 1'b1);
    tx_wait = 1'b0;
    wait_chk("stl.last.iowait", 1'b0);
    tick(); idle_chk("stl.end");

    // Reset mid-word.
    io_packet = 64'h8877665544332211;
    io_valid  = 8'hFF;
    tick();
    io_valid = 8'h00;
    tick();
    tick();
    beat("rmw.b2", 16'h6655, 2'b11);
    nreset = 1'b0;
    #1;
    idle_chk("rmw.async");
    #2;
    nreset = 1'b1;
    io_packet = 64'hC4C4C3C3C2C2C1C1;
    io_valid  = 8'hFF;
    wait_chk("rmw.iowait", 1'b0);
    tick();
    io_valid = 8'h00;
    beat("rmw.n0", 16'hC1C1, 2'b11);
    tick(); beat("rmw.n1", 16'hC2C2, 2'b11);
    tick(); tick();
    tick(); idle_chk("rmw.end");

    // tx_en dropped with a second word pending.
    io_packet = 64'hA4A4A3A3A2A2A1A1;
    io_valid  = 8'hFF;
    tick();
    tx_en     = 1'b0;
    io_packet = 64'hB4B4B3B3B2B2B1B1;
    beat("ten.a0", 16'hA1A1, 2'b11);
    tick(); beat("ten.a1", 16'hA2A2, 2'b11);
    tick(); beat("ten.a2", 16'hA3A3, 2'b11);
    tick(); beat("ten.a3", 16'hA4A4, 2'b11); wait_chk("ten.a3.iowait", 1'b1);
    tick(); idle_chk("ten.gap0"); wait_chk("ten.gap0.iowait", 1'b1);
    tick(); idle_chk("ten.gap1");
    tx_en = 1'b1;
    wait_chk("ten.resume.iowait", 1'b0);
    tick();
    io_valid = 8'h00;
    beat("ten.b0", 16'hB1B1, 2'b11);
    tick(); beat("ten.b1", 16'hB2B2, 2'b11);
    tick(); beat("ten.b2", 16'hB3B3, 2'b11);
    tick(); beat("ten.b3", 16'hB4B4, 2'b11);
    tick(); idle_chk("ten.end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
